// File: rtl/fft_mag_writer.sv
// fft_mag_writer
//   Writer side of the FFT-magnitude RAM. Takes one complex frame of
//   N_POINTS bins from an AXI-Stream source, converts each bin to an
//   alpha-max/beta-min magnitude estimate and writes it to RAM address
//   = bin index. A complete frame raises frame_ready (THD start) and the
//   RAM is held stable until frame_ack (THD done).
//
// Ports
//   clk, rst_n         system clock, async active-low reset
//   s_axis_tdata[31:0] bin: [15:0] real, [31:16] imag (two's complement)
//   s_axis_tvalid/tlast/tready  AXI-Stream handshake, tlast on last bin
//   ram_we/waddr/wdata spectrum RAM write port (registered)
//   frame_ready        level, RAM holds a complete frame
//   frame_ack          releases the frame (honoured only in HOLD)
//   frame_err          one-cycle pulse on early or missing tlast
//   frame_count[7:0]   completed frames, wraps
//
// state | meaning
// IDLE  | one cycle after reset before accepting data
// FILL  | accepting bins into the magnitude pipeline
// DRAIN | two cycles letting the last write leave the pipeline
// HOLD  | frame complete, RAM frozen until frame_ack
// SKIP  | resynchronising after a missing tlast, beats discarded
module fft_mag_writer #(
  parameter int N_POINTS = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic        ram_we,
  output logic [15:0] ram_waddr,
  output logic [15:0] ram_wdata,
  output logic        frame_ready,
  input  logic        frame_ack,
  output logic        frame_err,
  output logic [7:0]  frame_count
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FILL  = 3'd1;
  localparam logic [2:0] DRAIN = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] SKIP  = 3'd4;

  localparam logic [15:0] LAST_IDX = 16'(N_POINTS - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic        drain_q, drain_d;
  logic        s1_vld_q, s1_vld_d;
  logic [16:0] s1_a_q, s1_a_d;
  logic [16:0] s1_b_q, s1_b_d;
  logic [15:0] s1_idx_q, s1_idx_d;
  logic        ram_we_q, ram_we_d;
  logic [15:0] ram_waddr_q, ram_waddr_d;
  logic [15:0] ram_wdata_q, ram_wdata_d;
  logic        frame_ready_q, frame_ready_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  frame_count_q, frame_count_d;

  logic        accept;
  logic [16:0] re_ext, im_ext, abs_re, abs_im;
  logic [16:0] mx, mn;
  logic [17:0] mn3;
  logic [15:0] mag;

  assign s_axis_tready = (state_q == FILL) || (state_q == SKIP);
  assign accept        = s_axis_tvalid && s_axis_tready;

  // Sign-extend to 17 bits so |-32768| = 32768 is representable.
  assign re_ext = {s_axis_tdata[15], s_axis_tdata[15:0]};
  assign im_ext = {s_axis_tdata[31], s_axis_tdata[31:16]};
  assign abs_re = re_ext[16] ? (~re_ext + 17'd1) : re_ext;
  assign abs_im = im_ext[16] ? (~im_ext + 17'd1) : im_ext;

  // mag = max + 3*min/8; peaks at 45056 so the 16-bit truncation is lossless.
  assign mx  = (s1_a_q >= s1_b_q) ? s1_a_q : s1_b_q;
  assign mn  = (s1_a_q >= s1_b_q) ? s1_b_q : s1_a_q;
  assign mn3 = {1'b0, mn} + {mn, 1'b0};
  assign mag = 16'({1'b0, mx} + (mn3 >> 3));

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    drain_d       = drain_q;
    s1_vld_d      = 1'b0;
    s1_a_d        = s1_a_q;
    s1_b_d        = s1_b_q;
    s1_idx_d      = s1_idx_q;
    frame_ready_d = frame_ready_q;
    frame_err_d   = 1'b0;
    frame_count_d = frame_count_q;

    case (state_q)
      IDLE: state_d = FILL;
      FILL: begin
        if (accept) begin
          s1_vld_d = 1'b1;
          s1_a_d   = abs_re;
          s1_b_d   = abs_im;
          s1_idx_d = idx_q;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (s_axis_tlast) begin
              state_d = DRAIN;
              drain_d = 1'b0;
            end else begin
              frame_err_d = 1'b1;
              state_d     = SKIP;
            end
          end else if (s_axis_tlast) begin
            // Early tlast: beat is written, partial frame abandoned.
            frame_err_d = 1'b1;
            idx_d       = '0;
          end else begin
            idx_d = idx_q + 16'd1;
          end
        end
      end
      SKIP: begin
        if (accept && s_axis_tlast) begin
          state_d = FILL;
          idx_d   = '0;
        end
      end
      DRAIN: begin
        if (drain_q) begin
          state_d       = HOLD;
          frame_ready_d = 1'b1;
          frame_count_d = frame_count_q + 8'd1;
        end else begin
          drain_d = 1'b1;
        end
      end
      HOLD: begin
        if (frame_ack) begin
          frame_ready_d = 1'b0;
          state_d       = FILL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_we_d    = s1_vld_q;
    ram_waddr_d = s1_vld_q ? s1_idx_q : ram_waddr_q;
    ram_wdata_d = s1_vld_q ? mag : ram_wdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      drain_q       <= 1'b0;
      s1_vld_q      <= 1'b0;
      s1_a_q        <= '0;
      s1_b_q        <= '0;
      s1_idx_q      <= '0;
      ram_we_q      <= 1'b0;
      ram_waddr_q   <= '0;
      ram_wdata_q   <= '0;
      frame_ready_q <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      drain_q       <= drain_d;
      s1_vld_q      <= s1_vld_d;
      s1_a_q        <= s1_a_d;
      s1_b_q        <= s1_b_d;
      s1_idx_q      <= s1_idx_d;
      ram_we_q      <= ram_we_d;
      ram_waddr_q   <= ram_waddr_d;
      ram_wdata_q   <= ram_wdata_d;
      frame_ready_q <= frame_ready_d;
      frame_err_q   <= frame_err_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign ram_we      = ram_we_q;
  assign ram_waddr   = ram_waddr_q;
  assign ram_wdata   = ram_wdata_q;
  assign frame_ready = frame_ready_q;
  assign frame_err   = frame_err_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_fft_mag_writer.sv
module tb_fft_mag_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic        ram_we;
  logic [15:0] ram_waddr;
  logic [15:0] ram_wdata;
  logic        frame_ready;
  logic        frame_ack = 1'b0;
  logic        frame_err;
  logic [7:0]  frame_count;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int err_pulses = 0;
  logic [31:0] exp_q[$];

  fft_mag_writer #(.N_POINTS(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .frame_ready(frame_ready), .frame_ack(frame_ack),
    .frame_err(frame_err), .frame_count(frame_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every RAM write must match the oldest pending beat.
  always @(negedge clk) begin
    if (rst_n && ram_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_pending", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("waddr", {16'd0, ram_waddr}, {16'd0, e[31:16]});
        chk("wdata", {16'd0, ram_wdata}, {16'd0, e[15:0]});
      end
    end
    if (frame_err === 1'b1) err_pulses++;
  end

  function automatic logic [15:0] mag_model(input int re, input int im);
    int a, b, mx, mn;
    a  = (re < 0) ? -re : re;
    b  = (im < 0) ? -im : im;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    return 16'(mx + (3 * mn) / 8);
  endfunction

  // Entered and left at posedge+1.
  task automatic send(input logic [15:0] re, input logic [15:0] im, input logic last,
                      input logic push, input logic [15:0] addr, input logic [15:0] exp,
                      input int gap, output int acc_cyc);
    int n;
    repeat (gap) begin @(posedge clk); #1; end
    s_axis_tdata  = {im, re};
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
    n = 0;
    @(negedge clk);
    while (!s_axis_tready && n < 200) begin @(negedge clk); n++; end
    if (!s_axis_tready) begin
      chk("accept_timeout_tready", {31'd0, s_axis_tready}, 32'd1);
      acc_cyc = cyc;
    end else begin
      @(posedge clk);
      if (push) exp_q.push_back({addr, exp});
      #1;
      acc_cyc = cyc;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic full_frame(input int im_step, input int gapmax, output int k_last);
    for (int k = 0; k < 16; k++)
      send(16'(k * 100), 16'(-(k * im_step)), k == 15, 1'b1, 16'(k),
           mag_model(k * 100, -(k * im_step)), $urandom_range(0, gapmax), k_last);
  endtask

  task automatic wait_frame(input int k_last, input logic [7:0] exp_cnt);
    int n;
    n = 0;
    @(negedge clk);
    while (frame_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("frame_ready_rise", {31'd0, frame_ready}, 32'd1);
    chk("frame_ready_cycle", 32'(cyc), 32'(k_last + 2));
    chk("frame_count", {24'd0, frame_count}, {24'd0, exp_cnt});
    chk("writes_done_at_ready", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic ack_frame();
    @(posedge clk); #1;
    frame_ack = 1'b1;
    @(posedge clk); #1;
    frame_ack = 1'b0;
    chk("ack_frame_ready", {31'd0, frame_ready}, 32'd0);
    chk("ack_tready", {31'd0, s_axis_tready}, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_tready"}, {31'd0, s_axis_tready}, 32'd0);
    chk({tag, "_we"}, {31'd0, ram_we}, 32'd0);
    chk({tag, "_waddr"}, {16'd0, ram_waddr}, 32'd0);
    chk({tag, "_wdata"}, {16'd0, ram_wdata}, 32'd0);
    chk({tag, "_ready"}, {31'd0, frame_ready}, 32'd0);
    chk({tag, "_err"}, {31'd0, frame_err}, 32'd0);
    chk({tag, "_count"}, {24'd0, frame_count}, 32'd0);
  endtask

  initial begin
    int kl, e0, bad;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // Full frame re=k*100, im=0.
    full_frame(0, 0, kl);
    wait_frame(kl, 8'd1);

    // Back-pressure in HOLD with source valid.
    @(posedge clk); #1;
    s_axis_tdata  = 32'h0001_0001;
    s_axis_tvalid = 1'b1;
    bad = 0;
    repeat (50) begin @(negedge clk); if (s_axis_tready !== 1'b0) bad++; end
    chk("hold_tready_low_cycles", 32'(bad), 32'd0);
    chk("hold_frame_ready", {31'd0, frame_ready}, 32'd1);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    frame_ack = 1'b1;
    @(posedge clk); #1;
    frame_ack = 1'b0;
    chk("hold_ack_ready", {31'd0, frame_ready}, 32'd0);
    chk("hold_ack_tready", {31'd0, s_axis_tready}, 32'd1);

    // Magnitude corners at bins 0..3, rest of frame from the model.
    send(16'h8000, 16'h8000, 1'b0, 1'b1, 16'd0, 16'd45056, 0, kl);
    send(16'd3000, 16'(-4000), 1'b0, 1'b1, 16'd1, 16'd5125, 0, kl);
    send(16'd0, 16'd0, 1'b0, 1'b1, 16'd2, 16'd0, 0, kl);
    send(16'hFFFF, 16'd0, 1'b0, 1'b1, 16'd3, 16'd1, 0, kl);
    for (int k = 4; k < 16; k++)
      send(16'(k * 7), 16'(k * 1000), k == 15, 1'b1, 16'(k), mag_model(k * 7, k * 1000), 0, kl);
    wait_frame(kl, 8'd2);
    ack_frame();

    // Early tlast at bin 5.
    e0 = err_pulses;
    for (int k = 0; k < 6; k++)
      send(16'(k + 1), 16'd0, k == 5, 1'b1, 16'(k), 16'(k + 1), 0, kl);
    repeat (4) @(negedge clk);
    chk("early_err_pulses", 32'(err_pulses - e0), 32'd1);
    chk("early_no_ready", {31'd0, frame_ready}, 32'd0);
    chk("early_writes_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    full_frame(37, 1, kl);
    wait_frame(kl, 8'd3);
    ack_frame();

    // Missing tlast at bin 15, then 4 discarded beats.
    e0 = err_pulses;
    for (int k = 0; k < 16; k++)
      send(16'(k * 3), 16'(k * 5), 1'b0, 1'b1, 16'(k), mag_model(k * 3, k * 5), 0, kl);
    for (int k = 0; k < 4; k++)
      send(16'h1234, 16'h0042, k == 3, 1'b0, 16'd0, 16'd0, 0, kl);
    repeat (4) @(negedge clk);
    chk("missing_err_pulses", 32'(err_pulses - e0), 32'd1);
    chk("missing_no_ready", {31'd0, frame_ready}, 32'd0);
    chk("missing_writes_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    full_frame(11, 0, kl);
    wait_frame(kl, 8'd4);
    ack_frame();

    // Random gaps, then reset with bin 7 inside the pipeline.
    for (int k = 0; k < 7; k++)
      send(16'(k * 9), 16'(k * 2), 1'b0, 1'b1, 16'(k), mag_model(k * 9, k * 2),
           $urandom_range(0, 3), kl);
    repeat (3) begin @(posedge clk); #1; end
    chk("midreset_writes_drained", 32'(exp_q.size()), 32'd0);
    send(16'd500, 16'd500, 1'b0, 1'b0, 16'd7, 16'd0, 0, kl);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    full_frame(23, 2, kl);
    wait_frame(kl, 8'd1);
    ack_frame();

    repeat (5) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
